// File: rtl/peripheral_operand_loader.sv
// Byte-serial operand loader: one switch byte per debounced enter press, LSB first, then pages the result onto four 7-seg digits.
// Latency: enter edge -> operand byte write two clocks later; no backpressure, loaddata low aborts to IDLE.
module peripheral_operand_loader #(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enter,
    input  logic [7:0]                inputdata,
    input  logic                      loaddata,
    input  logic [DATA_W-1:0]         dataR,
    output logic [NUM_OPS*DATA_W-1:0] operands,
    output logic                      inputdata_ready,
    output logic                      busy,
    output logic [6:0]                disp3,
    output logic [6:0]                disp2,
    output logic [6:0]                disp1,
    output logic [6:0]                disp0
);

    localparam int BYTES = DATA_W / 8;
    localparam int PAGES = DATA_W / 16;
    localparam int OP_W  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int BI_W  = $clog2(BYTES);
    localparam int PG_W  = (PAGES > 1) ? $clog2(PAGES) : 1;

    localparam logic [OP_W-1:0] OP_MAX = OP_W'(NUM_OPS - 1);
    localparam logic [BI_W-1:0] BI_MAX = BI_W'(BYTES - 1);
    localparam logic [PG_W-1:0] PG_MAX = PG_W'(PAGES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_SHOW  = 2'd3
    } state_t;

    state_t                      state_q;
    logic                        enter_s1_q, enter_s2_q, enter_s3_q;
    logic [OP_W-1:0]             op_idx_q;
    logic [BI_W-1:0]             byte_idx_q;
    logic [PG_W-1:0]             page_q;
    logic [NUM_OPS*DATA_W-1:0]   operands_q;
    logic                        ready_q;
    logic                        busy_q;
    logic                        enter_pulse;
    int                          wr_sel;
    logic [15:0]                 disp_val;

    // enter is a raw button: two flops for metastability, third for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_s1_q <= 1'b0;
            enter_s2_q <= 1'b0;
            enter_s3_q <= 1'b0;
        end else begin
            enter_s1_q <= enter;
            enter_s2_q <= enter_s1_q;
            enter_s3_q <= enter_s2_q;
        end
    end

    assign enter_pulse = enter_s2_q & ~enter_s3_q;
    assign wr_sel      = int'(op_idx_q) * BYTES + int'(byte_idx_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_idx_q   <= '0;
            byte_idx_q <= '0;
            page_q     <= '0;
            operands_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (loaddata) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!loaddata) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        op_idx_q   <= '0;
                        byte_idx_q <= '0;
                    end else if (enter_pulse) begin
                        for (int k = 0; k < NUM_OPS * BYTES; k++) begin
                            if (k == wr_sel) operands_q[k*8 +: 8] <= inputdata;
                        end
                        if (byte_idx_q == BI_MAX) begin
                            byte_idx_q <= '0;
                            if (op_idx_q == OP_MAX) begin
                                op_idx_q <= '0;
                                state_q  <= ST_READY;
                                busy_q   <= 1'b0;
                                ready_q  <= 1'b1;
                            end else begin
                                op_idx_q <= op_idx_q + OP_W'(1);
                            end
                        end else begin
                            byte_idx_q <= byte_idx_q + BI_W'(1);
                        end
                    end
                end
                ST_READY: begin
                    page_q  <= '0;
                    state_q <= loaddata ? ST_SHOW : ST_IDLE;
                end
                ST_SHOW: begin
                    if (!loaddata) begin
                        state_q <= ST_IDLE;
                        page_q  <= '0;
                    end else if (enter_pulse) begin
                        page_q <= (page_q == PG_MAX) ? '0 : page_q + PG_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        disp_val = '0;
        if (state_q == ST_IDLE || state_q == ST_LOAD) begin
            disp_val = {4'(op_idx_q), 4'(byte_idx_q), inputdata};
        end else begin
            for (int p = 0; p < PAGES; p++) begin
                if (int'(page_q) == p) disp_val = dataR[p*16 +: 16];
            end
        end
    end

    assign disp3           = seg7(disp_val[15:12]);
    assign disp2           = seg7(disp_val[11:8]);
    assign disp1           = seg7(disp_val[7:4]);
    assign disp0           = seg7(disp_val[3:0]);
    assign operands        = operands_q;
    assign inputdata_ready = ready_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_peripheral_operand_loader.sv
// Randomized bench for peripheral_operand_loader against a press-level reference model.
module tb_peripheral_operand_loader;

    localparam int DATA_W  = 32;
    localparam int NUM_OPS = 2;
    localparam int BYTES   = DATA_W / 8;
    localparam int PAGES   = DATA_W / 16;
    localparam int TOTAL   = NUM_OPS * BYTES;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      enter;
    logic [7:0]                inputdata;
    logic                      loaddata;
    logic [DATA_W-1:0]         dataR;
    logic [NUM_OPS*DATA_W-1:0] operands;
    logic                      inputdata_ready;
    logic                      busy;
    logic [6:0]                disp3, disp2, disp1, disp0;

    peripheral_operand_loader #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS)) dut (
        .clk(clk), .reset(reset), .enter(enter), .inputdata(inputdata),
        .loaddata(loaddata), .dataR(dataR), .operands(operands),
        .inputdata_ready(inputdata_ready), .busy(busy),
        .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: flat byte array, linear byte counter, mode 0=idle 1=load 2=show
    logic [7:0] m_bytes [TOTAL];
    int m_idx = 0;
    int m_page = 0;
    int m_mode = 0;
    int m_ready_exp = 0;

    int ready_seen = 0;
    int ready_run = 0;
    int ready_maxrun = 0;

    always @(negedge clk) begin
        if (inputdata_ready) begin
            ready_seen++;
            ready_run++;
            if (ready_run > ready_maxrun) ready_maxrun = ready_run;
        end else begin
            ready_run = 0;
        end
    end

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] g [16];
        g = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return g[n];
    endfunction

    function automatic logic [27:0] glyphs(input logic [15:0] v);
        return {seg(v[15:12]), seg(v[11:8]), seg(v[7:4]), seg(v[3:0])};
    endfunction

    function automatic logic [27:0] exp_disp();
        logic [15:0] v;
        if (m_mode == 2) v = dataR[m_page*16 +: 16];
        else             v = {4'(m_idx / BYTES), 4'(m_idx % BYTES), inputdata};
        return glyphs(v);
    endfunction

    task automatic check_all(input string tag);
        logic [63:0] ops;
        ops = '0;
        for (int i = 0; i < TOTAL; i++) ops[i*8 +: 8] = m_bytes[i];
        chk({tag, ".ops"}, 64'(operands), ops);
        chk({tag, ".busy"}, 64'(busy), 64'(m_mode == 1));
        chk({tag, ".disp"}, 64'({disp3, disp2, disp1, disp0}), 64'(exp_disp()));
        chk({tag, ".rdycnt"}, 64'(ready_seen), 64'(m_ready_exp));
    endtask

    task automatic model_clear();
        for (int i = 0; i < TOTAL; i++) m_bytes[i] = 8'h00;
        m_idx = 0;
        m_page = 0;
        m_mode = 0;
    endtask

    task automatic press(input logic [7:0] b, input int hold);
        inputdata = b;
        enter = 1'b1;
        repeat (hold) @(posedge clk);
        #1 enter = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        if (m_mode == 1) begin
            m_bytes[m_idx] = b;
            m_idx++;
            if (m_idx == TOTAL) begin
                m_idx = 0;
                m_mode = 2;
                m_page = 0;
                m_ready_exp++;
            end
        end else if (m_mode == 2) begin
            m_page = (m_page + 1) % PAGES;
        end
        @(negedge clk);
    endtask

    task automatic set_load(input logic v);
        loaddata = v;
        repeat (2) @(posedge clk);
        #1;
        if (v && m_mode == 0) begin
            m_mode = 1;
            m_idx = 0;
        end else if (!v) begin
            m_mode = 0;
            m_idx = 0;
            m_page = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        enter = 1'b0;
        loaddata = 1'b0;
        inputdata = 8'h00;
        dataR = '0;
        model_clear();
        #1;
        check_all("reset");
        chk("reset.disp0", 64'(disp0), 64'(7'b1000000));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        press(8'h3C, 20);
        check_all("idle_hold");

        set_load(1'b1);
        check_all("enter_load");
        for (int i = 0; i < TOTAL; i++) begin
            press(8'((i + 1) * 8'h11), 3);
            check_all("seq");
        end
        chk("opA", 64'(operands[31:0]), 64'(32'h44332211));
        chk("opB", 64'(operands[63:32]), 64'(32'h88776655));
        chk("rdy_width", 64'(ready_maxrun), 64'd1);

        dataR = 32'hDEADBEEF;
        #1;
        chk("show.beef", 64'({disp3, disp2, disp1, disp0}), 64'(glyphs(16'hBEEF)));
        press(8'h00, 3);
        chk("show.dead", 64'({disp3, disp2, disp1, disp0}), 64'(glyphs(16'hDEAD)));
        press(8'h00, 3);
        chk("show.wrap", 64'({disp3, disp2, disp1, disp0}), 64'(glyphs(16'hBEEF)));
        check_all("show");

        set_load(1'b0);
        check_all("abort_show");
        set_load(1'b1);
        press(8'hA5, 50);
        check_all("long_hold");
        for (int i = 0; i < 4; i++) press(8'($urandom), 3);
        set_load(1'b0);
        check_all("abort5");
        chk("abort5.Bhi", 64'(operands[63:40]), 64'(24'h887766));
        set_load(1'b1);
        press(8'h5E, 3);
        chk("reload.A0", 64'(operands[7:0]), 64'h5E);
        check_all("reload");
        for (int i = 1; i < TOTAL; i++) press(8'($urandom), 3);
        dataR = $urandom;
        #1;
        check_all("reload_done");

        for (int it = 0; it < 4; it++) begin
            set_load(1'b0);
            set_load(1'b1);
            dataR = $urandom;
            n = $urandom_range(1, TOTAL + 3);
            for (int i = 0; i < n; i++) begin
                press(8'($urandom), $urandom_range(1, 6));
                check_all("rand");
            end
        end

        set_load(1'b0);
        set_load(1'b1);
        for (int i = 0; i < 3; i++) press(8'($urandom), 3);
        @(posedge clk);
        #3 reset = 1'b1;
        loaddata = 1'b0;
        model_clear();
        #1;
        check_all("arst");
        chk("arst.rdy", 64'(inputdata_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        press(8'hC3, 3);
        check_all("post_rst_ignored");
        set_load(1'b1);
        press(8'h77, 3);
        check_all("post_rst_load");
        chk("end.rdy_width", 64'(ready_maxrun), 64'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
